video_scanout_timing: RTL and testbench
=======================================

Name: video_scanout_timing

Overview:
- Downstream consumer of the framebuffer read stream: takes 16-bit RGB565 pixels over a valid/ready handshake and produces VGA raster timing (hsync, vsync, blank) plus 8-bit-per-channel RGB.
- Issues the `frame_sync` pulse that restarts the upstream framebuffer read at each frame, inside vertical blanking, so the upstream FIFO refills before active video.
- Counts pixel underruns for software visibility.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- UNDERRUN_RGB, 16'hF81F, RGB565 value substituted on underrun

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-rate strobe; all raster advance happens only when high
- valid  in  1  upstream pixel available
- readdata  in  16  upstream pixel, RGB565 {r[4:0],g[5:0],b[4:0]}
- ready  out  1  pixel consumed this cycle
- frame_sync  out  1  one-cycle pulse: restart upstream frame read
- vga_r / vga_g / vga_b  out  8 each  colour outputs
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_blank_n  out  1  low outside active area
- underrun_count  out  16  saturating count of underrun pixels
- underrun_clr  in  1  clears underrun_count

Behaviour:
- Counters:
  - h_cnt is 11 bits, range 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt is 10 bits, range 0..V_TOT-1, defined the same way.
  - Both advance only on pix_en. h_cnt wraps to 0 and increments v_cnt. v_cnt wraps to 0 at V_TOT-1.
- Regions:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs uses the same form on v_cnt.
- Reset state:
  - h_cnt = 0, v_cnt = V_ACTIVE (start of front porch), so the first frame begins with blanking.
  - Output reset values: ready = 0, frame_sync = 0, RGB = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0, underrun_count = 0.
- State machine:
  - PRIME (entered on reset): outputs blanked, ready held 0. On the first pix_en, emit frame_sync and go to RUN.
  - RUN: normal scanout.
- frame_sync in RUN:
  - Pulses for exactly one clk cycle when pix_en && h_cnt == 0 && v_cnt == V_ACTIVE.
  - This gives one pulse per frame, at the first blank line.
  - It is never asserted while active.
- Handshake:
  - ready = pix_en && active && (state == RUN). This is combinational from registered counters.
  - A pixel is transferred when ready && valid. ready does not wait for valid.
- Underrun:
  - Occurs when ready && !valid.
  - The output pixel is UNDERRUN_RGB.
  - underrun_count increments, saturating at 16'hFFFF.
  - underrun_clr has priority over increment; with simultaneous clear and underrun the result is 0.
- Output pipeline:
  - One register stage, updated on pix_en.
  - RGB, hs, vs and blank_n for raster position (h,v) all appear together one pix_en after that position is evaluated.
  - Outside active: RGB = 0, blank_n = 0.
- Colour expansion:
  - r8 = {r5, r5[4:2]}
  - g8 = {g6, g6[5:4]}
  - b8 = {b5, b5[4:2]}
- pix_en low: all counters and output registers hold; ready = 0; frame_sync = 0.
- Reset mid-frame: synchronous return to the reset state next clk. This yields one frame_sync pulse on the first pix_en after reset release.

Optional Feature:
- Macro: VIDEO_SCANOUT_TESTPAT_EN.
- When defined:
  - Adds input test_pattern (1 bit).
  - While high, ready is forced 0, no underruns are counted, and active pixels show 8 vertical colour bars.
  - Bar index = h_cnt*8/H_ACTIVE; bar colour = {R=idx[2],G=idx[1],B=idx[0]}, each bit expanded to 8'hFF or 8'h00.
  - Timing and frame_sync are unchanged.
- When undefined: the port is absent and the behaviour is as above.

Test Plan:
- Reset, pix_en every cycle, default params → frame_sync exactly one pulse, on the first clk after reset, then every 800*525 = 420000 clks; never while vga_blank_n = 1.
- Small params (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1) → vga_hs low for 2 pix per 8-pixel line; vga_vs low for 1 line per 5-line frame; blank_n high for 4 pix on v=0,1 only.
- valid held 1, readdata = 16'hF800 → vga_r = 8'hFF, g = 0, b = 0 on active pixels; readdata = 16'h07E0 → g = 8'hFF; one pix_en latency from ready to colour.
- valid low for 3 active pixels → those pixels show R=8'hFF, G=0, B=8'hFF; underrun_count = 3; underrun_clr pulse → 0; clr coincident with underrun → 0.
- pix_en every 2nd clk → ready only on pix_en cycles; frame period doubles to 840000 clks; frame_sync width still 1 clk.
- Assert rst mid-active line → next cycle outputs blanked, ready = 0, hs/vs = 1; after release frame_sync fires on first pix_en and scanout restarts at v=V_ACTIVE.

Source files
------------

// File: rtl/video_scanout_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_scanout_timing_if
//  Description : Pixel stream from the framebuffer reader to the scanout
//                timing block. A pixel is transferred in any cycle where
//                ready && valid.
//                  valid    : upstream pixel available
//                  readdata : RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//                  ready    : downstream consumes the pixel this cycle
//                Modports: master = framebuffer side, slave = scanout side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_scanout_timing_if;
    logic        valid;
    logic [15:0] readdata;
    logic        ready;

    modport master (output valid, output readdata, input ready);
    modport slave  (input valid, input readdata, output ready);
endinterface
`default_nettype wire

// File: rtl/video_scanout_timing.sv
`default_nettype none
// ============================================================================
//  Module      : video_scanout_timing
//  Description : VGA raster timing generator and pixel sink. Pulls RGB565
//                pixels from the framebuffer stream during active video,
//                expands them to 8 bits per channel and registers them
//                together with hsync/vsync/blank. Issues frame_sync at the
//                first vertical-blank line so the upstream reader restarts
//                and refills before the next active region.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                pix_en            - pixel-rate strobe (raster advances only here)
//                pix               - pixel stream (slave modport)
//                frame_sync        - one-cycle restart pulse to upstream
//                vga_r/g/b         - 8-bit colour outputs
//                vga_hs, vga_vs    - active-low syncs
//                vga_blank_n       - low outside the active area
//                underrun_count    - saturating count of starved pixels
//                underrun_clr      - clears underrun_count (wins over increment)
//                test_pattern      - only with VIDEO_SCANOUT_TESTPAT_EN defined
//  Options     : `define VIDEO_SCANOUT_TESTPAT_EN adds the test_pattern input
//                which shows 8 vertical colour bars and stops consuming pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_scanout_timing #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic [15:0] UNDERRUN_RGB = 16'hF81F
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_en,
    video_scanout_timing_if.slave        pix,
    output logic                         frame_sync,
    output logic [7:0]                   vga_r,
    output logic [7:0]                   vga_g,
    output logic [7:0]                   vga_b,
    output logic                         vga_hs,
    output logic                         vga_vs,
    output logic                         vga_blank_n,
    output logic [15:0]                  underrun_count,
    input  logic                         underrun_clr
`ifdef VIDEO_SCANOUT_TESTPAT_EN
    ,
    input  logic                         test_pattern
`endif
);

    // ------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------
    localparam logic [10:0] c_h_act      = 11'(H_ACTIVE);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_h_last     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  c_v_act      = 10'(V_ACTIVE);
    localparam logic [9:0]  c_vs_start   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  c_v_last     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [0:0] {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         w_frame_sync;

    logic [10:0]  r_h_cnt;
    logic [9:0]   r_v_cnt;
    logic [23:0]  r_rgb;
    logic         r_hs;
    logic         r_vs;
    logic         r_blank_n;
    logic [15:0]  r_underrun_count;

    logic         w_active;
    logic         w_run;
    logic         w_hs_on;
    logic         w_vs_on;
    logic         w_tpat;
    logic         w_ready;
    logic         w_underrun;
    logic [23:0]  w_pix;

    function automatic logic [23:0] f_expand565(input logic [15:0] p);
        // Replicate the MSBs into the new LSBs so full-scale maps to 8'hFF.
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // ------------------------------------------------------------------
    // Raster counters. Reset parks at the first front-porch line so the
    // first frame opens with blanking and the upstream has time to fill.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= c_v_act;
        end else if (pix_en) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 11'd1;
            end
        end
    end

    assign w_active = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs_on  = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs_on  = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    assign w_run    = (r_state == S_RUN);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_sync = 1'b0;
        case (r_state)
            S_PRIME: begin
                if (pix_en) begin
                    w_frame_sync = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (pix_en && (r_h_cnt == '0) && (r_v_cnt == c_v_act)) begin
                    w_frame_sync = 1'b1;
                end
            end
            default: begin
                w_state_next = S_PRIME;
            end
        endcase
    end

    // While reset is held the FSM sits in PRIME; without this gate every
    // pix_en during reset would look like a fresh restart request.
    assign frame_sync = w_frame_sync && !rst;

    // ------------------------------------------------------------------
    // Pixel handshake and colour selection
    // ------------------------------------------------------------------
`ifdef VIDEO_SCANOUT_TESTPAT_EN
    logic [13:0] w_bar_num;
    logic [2:0]  w_bar_idx;

    assign w_tpat    = test_pattern;
    assign w_bar_num = {r_h_cnt, 3'b000};
    assign w_bar_idx = 3'(w_bar_num / 14'(H_ACTIVE));
`else
    assign w_tpat    = 1'b0;
`endif

    // ready never waits for valid: the raster cannot stall, so a missing
    // pixel is an underrun rather than back-pressure.
    assign w_ready    = pix_en && w_active && w_run && !w_tpat;
    assign w_underrun = w_ready && !pix.valid;
    assign pix.ready  = w_ready;

    always_comb begin
        w_pix = f_expand565(UNDERRUN_RGB);
        if (pix.valid) begin
            w_pix = f_expand565(pix.readdata);
        end
`ifdef VIDEO_SCANOUT_TESTPAT_EN
        if (w_tpat) begin
            w_pix = {{8{w_bar_idx[2]}}, {8{w_bar_idx[1]}}, {8{w_bar_idx[0]}}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output stage: colour, syncs and blank for one raster position are
    // registered together so they stay aligned at the pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb     <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else if (pix_en) begin
            r_hs <= !w_hs_on;
            r_vs <= !w_vs_on;
            if (w_active && w_run) begin
                r_rgb     <= w_pix;
                r_blank_n <= 1'b1;
            end else begin
                r_rgb     <= '0;
                r_blank_n <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun_count <= '0;
        end else if (underrun_clr) begin
            r_underrun_count <= '0;
        end else if (w_underrun && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign vga_r          = r_rgb[23:16];
    assign vga_g          = r_rgb[15:8];
    assign vga_b          = r_rgb[7:0];
    assign vga_hs         = r_hs;
    assign vga_vs         = r_vs;
    assign vga_blank_n    = r_blank_n;
    assign underrun_count = r_underrun_count;

endmodule
`default_nettype wire

// File: tb/tb_video_scanout_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_scanout_timing
//  Description : Self-checking bench for video_scanout_timing using a small
//                raster (8 x 5). A behavioural raster model predicts ready and
//                frame_sync each cycle and pushes the expected registered
//                output for every pix_en into a scoreboard queue, which is
//                popped when the DUT presents that pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_scanout_timing;

    localparam int H_ACTIVE = 4;
    localparam int H_FP     = 1;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 1;
    localparam int V_ACTIVE = 2;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        underrun_clr;
    logic        tpat;
    logic        frame_sync;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [15:0] underrun_count;

    video_scanout_timing_if bus ();

    video_scanout_timing #(
        .H_ACTIVE     (H_ACTIVE),
        .H_FP         (H_FP),
        .H_SYNC       (H_SYNC),
        .H_BP         (H_BP),
        .V_ACTIVE     (V_ACTIVE),
        .V_FP         (V_FP),
        .V_SYNC       (V_SYNC),
        .V_BP         (V_BP),
        .UNDERRUN_RGB (16'hF81F)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_en         (pix_en),
        .pix            (bus),
        .frame_sync     (frame_sync),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .vga_hs         (vga_hs),
        .vga_vs         (vga_vs),
        .vga_blank_n    (vga_blank_n),
        .underrun_count (underrun_count),
        .underrun_clr   (underrun_clr)
`ifdef VIDEO_SCANOUT_TESTPAT_EN
        ,
        .test_pattern   (tpat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank_n;
    } out_t;

    out_t        q[$];
    out_t        m_cur;
    int          mh;
    int          mv;
    bit          m_run;
    bit          m_known;
    bit          m_fresh;
    logic [15:0] m_cnt;

    int n_pass;
    int n_fail;
    int n_chk;
    int win_hs_low;
    int win_vs_low;
    int win_blank_hi;
    int win_fs;
    int fs_while_active;

    function automatic logic [23:0] exp565(input logic [15:0] p);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = p[15:11];
        g6 = p[10:5];
        b5 = p[4:0];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_active();
        return (mh < H_ACTIVE) && (mv < V_ACTIVE);
    endfunction

    // One clk cycle: drive inputs after the falling edge, check the DUT
    // against the model a little later, then advance the model as the
    // coming rising edge will advance the DUT.
    task automatic step(input logic a_rst, input logic pe, input logic vl,
                        input logic [15:0] rd, input logic clr);
        logic act;
        logic e_ready;
        logic e_fs;
        out_t o;
        @(negedge clk);
        rst          = a_rst;
        pix_en       = pe;
        bus.valid    = vl;
        bus.readdata = rd;
        underrun_clr = clr;
        #1;
        act     = m_active();
        e_ready = pe && act && m_run;
        e_fs    = pe && (!m_run || (mh == 0 && mv == V_ACTIVE));
        if (m_known) begin
            if (m_fresh) begin
                m_cur   = q.pop_front();
                m_fresh = 1'b0;
            end
            if (!a_rst) begin
                check("ready", 32'(bus.ready), 32'(e_ready));
                check("frame_sync", 32'(frame_sync), 32'(e_fs));
            end
            check("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, m_cur.rgb});
            check("hs", 32'(vga_hs), 32'(m_cur.hs));
            check("vs", 32'(vga_vs), 32'(m_cur.vs));
            check("blank_n", 32'(vga_blank_n), 32'(m_cur.blank_n));
            check("underrun_count", 32'(underrun_count), 32'(m_cnt));
            if (!vga_hs)      win_hs_low++;
            if (!vga_vs)      win_vs_low++;
            if (vga_blank_n)  win_blank_hi++;
            if (frame_sync)   win_fs++;
            if (frame_sync && vga_blank_n) fs_while_active++;
        end
        if (a_rst) begin
            mh      = 0;
            mv      = V_ACTIVE;
            m_run   = 1'b0;
            m_cnt   = '0;
            q.delete();
            m_cur   = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
            m_fresh = 1'b0;
            m_known = 1'b1;
        end else begin
            if (clr) begin
                m_cnt = '0;
            end else if (e_ready && !vl && m_cnt != 16'hFFFF) begin
                m_cnt = m_cnt + 16'd1;
            end
            if (pe) begin
                o.blank_n = act && m_run;
                o.rgb     = !(act && m_run) ? 24'h0 : (vl ? exp565(rd) : exp565(16'hF81F));
                o.hs      = !(mh >= H_ACTIVE + H_FP && mh < H_ACTIVE + H_FP + H_SYNC);
                o.vs      = !(mv >= V_ACTIVE + V_FP && mv < V_ACTIVE + V_FP + V_SYNC);
                q.push_back(o);
                m_fresh = 1'b1;
                m_run   = 1'b1;
                if (mh == H_TOT - 1) begin
                    mh = 0;
                    mv = (mv == V_TOT - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
    endtask

    task automatic clear_window();
        win_hs_low   = 0;
        win_vs_low   = 0;
        win_blank_hi = 0;
        win_fs       = 0;
    endtask

    // Run pixels with valid data until the model sits at (h_target, any
    // active line); reports a failed check if the bound expires.
    task automatic seek_active(input int h_target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_run && m_active() && mh == h_target) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b0);
        end
        check("seek_active", 32'(found), 32'd1);
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_chk = 0;
        fs_while_active = 0;
        clear_window();
        mh = 0; mv = V_ACTIVE; m_run = 1'b0; m_known = 1'b0; m_fresh = 1'b0;
        m_cnt = '0;
        m_cur = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
        rst = 1'b1; pix_en = 1'b0; underrun_clr = 1'b0; tpat = 1'b0;
        bus.valid = 1'b0; bus.readdata = '0;

        // Reset, then a full frame of pure red (reset outputs checked first).
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        clear_window();
        for (int i = 0; i < H_TOT * V_TOT; i++) step(1'b0, 1'b1, 1'b1, 16'hF800, 1'b0);
        check("fs_first_frame", 32'(win_fs), 32'd1);

        // Second frame of pure green: exactly one frame of outputs observed.
        clear_window();
        for (int i = 0; i < H_TOT * V_TOT; i++) step(1'b0, 1'b1, 1'b1, 16'h07E0, 1'b0);
        check("hs_low_per_frame", 32'(win_hs_low), 32'(H_SYNC * V_TOT));
        check("vs_low_per_frame", 32'(win_vs_low), 32'(H_TOT * V_SYNC));
        check("blank_hi_per_frame", 32'(win_blank_hi), 32'(H_ACTIVE * V_ACTIVE));
        check("fs_per_frame", 32'(win_fs), 32'd1);

        // Three starved active pixels.
        seek_active(0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h1234, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1, 16'h001F, 1'b0);
        check("underrun_three", 32'(underrun_count), 32'd3);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        check("underrun_cleared", 32'(underrun_count), 32'd0);

        // Clear coincident with an underrun leaves zero.
        seek_active(1);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        check("clr_beats_underrun", 32'(underrun_count), 32'd0);

        // pix_en on every second clk with random data and valid.
        clear_window();
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++)
            step(1'b0, 1'(i % 2 == 0), 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'b0);
        check("fs_per_slow_frame", 32'(win_fs), 32'd1);

        // Random pix_en, valid, data and occasional clears.
        for (int i = 0; i < 150; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 16'($urandom), 1'($urandom_range(0, 19) == 0));

        // Reset in the middle of an active line, then restart.
        seek_active(2);
        step(1'b1, 1'b1, 1'b1, 16'hABCD, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0);
        check("rst_blank", 32'(vga_blank_n), 32'd0);
        check("rst_hs", 32'(vga_hs), 32'd1);
        clear_window();
        step(1'b0, 1'b1, 1'b1, 16'h07FF, 1'b0);
        check("fs_after_rst", 32'(win_fs), 32'd1);
        for (int i = 0; i < H_TOT * V_TOT + 5; i++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 4) != 0), 16'($urandom), 1'b0);

        check("fs_never_active", 32'(fs_while_active), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
